// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Instruction buffer between fetch (F) and decode (D). Replaces the plain
//   IF/ID register: up to DEPTH fetched {Instr, PC} words are held in a small
//   FIFO so fetch can keep running while decode stalls. The head entry drives
//   the decode stage combinationally.
//
// Parameters
//   DEPTH    number of entries (power of two, >= 2)
//   AW       pointer width, log2(DEPTH)
//
// Ports
//   clk      in   pipeline clock, rising edge
//   reset    in   asynchronous, active-low reset
//   Instr_F  in   fetched instruction
//   PC_F     in   PC of Instr_F
//   Valid_F  in   Instr_F/PC_F valid this cycle
//   Ready_F  out  queue accepts a push this cycle
//   Stall_D  in   decode holds its current instruction (no pop)
//   Flush    in   discard all queued entries (redirect/exception)
//   Instr_D  out  head instruction, 0 (nop) when empty
//   PC_D     out  head PC, 0 when empty
//   PC8_D    out  PC_D + 8 (link address), 0 when empty
//   Imm_D    out  Instr_D[15:0], to the immediate extender
//   Valid_D  out  head entry valid
//   Count    out  occupancy, 0..DEPTH
//
// Build option
//   IFQ_BYPASS_EN  when defined, an empty queue forwards Instr_F/PC_F to the
//                  decode outputs in the same cycle. Undefined (default): no
//                  combinational F->D path, minimum latency one cycle.
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   Instr_F,
  input  logic [31:0]   PC_F,
  input  logic          Valid_F,
  output logic          Ready_F,
  input  logic          Stall_D,
  input  logic          Flush,
  output logic [31:0]   Instr_D,
  output logic [31:0]   PC_D,
  output logic [31:0]   PC8_D,
  output logic [15:0]   Imm_D,
  output logic          Valid_D,
  output logic [AW:0]   Count
);

  // Storage is deliberately not reset; occupancy alone decides validity.
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic          empty;
  logic          full;
  logic          bypass;
  logic          head_valid;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;
  logic          push;
  logic          pop;
  logic          pop_mem;

  // -------------------------------------------------------------------------
  // Head selection and handshake
  // -------------------------------------------------------------------------
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AW+1)'(DEPTH));
    // Ready depends on registered occupancy only: a full queue refuses a
    // push even when the head is being popped in the same cycle.
    Ready_F = ~full;

`ifdef IFQ_BYPASS_EN
    bypass     = empty & Valid_F & ~Flush;
    head_valid = ~empty | bypass;
    head_instr = empty ? Instr_F : instr_q[rd_ptr_q];
    head_pc    = empty ? PC_F    : pc_q[rd_ptr_q];
`else
    bypass     = 1'b0;
    head_valid = ~empty;
    head_instr = instr_q[rd_ptr_q];
    head_pc    = pc_q[rd_ptr_q];
`endif

    pop     = head_valid & ~Stall_D & ~Flush;
    // A bypassed word consumed by decode in the same cycle is never stored.
    push    = Valid_F & ~full & ~Flush & ~(bypass & pop);
    // Only a pop of a stored entry moves the read side.
    pop_mem = pop & ~bypass;
  end

  // -------------------------------------------------------------------------
  // Pointer / occupancy next state
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_mem) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop_mem})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= Instr_F;
      pc_q[wr_ptr_q]    <= PC_F;
    end
  end

  // -------------------------------------------------------------------------
  // Decode-side outputs, forced to zero (nop) when no valid head
  // -------------------------------------------------------------------------
  always_comb begin
    Valid_D = head_valid;
    Instr_D = head_valid ? head_instr : '0;
    PC_D    = head_valid ? head_pc : '0;
    PC8_D   = head_valid ? (head_pc + 32'd8) : '0;
    Imm_D   = Instr_D[15:0];
    Count   = count_q;
  end

endmodule
